i2s_transmitter: RTL and testbench



---
 rtl/i2s_tx_if.sv | 12 +
 rtl/i2s_transmitter.sv | 98 +++++++++
 tb/tb_i2s_transmitter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/i2s_tx_if.sv
// Upstream sample-pair handshake into the I2S transmitter holding buffer.
interface i2s_tx_if #(
  parameter int DATA_WIDTH = 24
);
  logic [DATA_WIDTH-1:0] din_left;
  logic [DATA_WIDTH-1:0] din_right;
  logic                  din_valid;
  logic                  din_ready;

  modport master (output din_left, output din_right, output din_valid, input din_ready);
  modport slave  (input din_left, input din_right, input din_valid, output din_ready);
endinterface

// File: rtl/i2s_transmitter.sv
// Standard I2S serialiser: stereo pair from a one-entry holding buffer, MSB first,
// one-bit delay after each externally driven LRCLK transition.
module i2s_transmitter #(
  parameter int DATA_WIDTH = 24
) (
  input  logic     sclk,
  input  logic     rst,
  input  logic     lrclk,
  i2s_tx_if.slave  up,
  output logic     sdout,
  output logic     frame_start,
  output logic     underrun
);
  localparam int CW = $clog2(DATA_WIDTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                state_q, state_d;
  logic                  prev_lr;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] hold_l, hold_r, act_l, act_r, act_l_d, act_r_d;
  logic                  hold_full, hold_clr;
  logic                  sdout_d, fs_d, ur_d;
  logic                  lr_edge, fall, accept;

  assign lr_edge     = lrclk ^ prev_lr;
  assign fall        = lr_edge & ~lrclk;
  assign up.din_ready = ~hold_full & ~rst;
  assign accept      = up.din_valid & up.din_ready;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sdout_d  = 1'b0;
    fs_d     = 1'b0;
    ur_d     = 1'b0;
    hold_clr = 1'b0;
    act_l_d  = act_l;
    act_r_d  = act_r;
    if (lr_edge) begin
      // Any edge restarts serialisation, truncating a word still in flight.
      state_d = SHIFT;
      cnt_d   = CW'(DATA_WIDTH - 2);
      if (fall) begin
        fs_d = 1'b1;
        if (hold_full) begin
          act_l_d  = hold_l;
          act_r_d  = hold_r;
          hold_clr = 1'b1;
        end else begin
          act_l_d = '0;
          act_r_d = '0;
          ur_d    = 1'b1;
        end
        sdout_d = act_l_d[DATA_WIDTH-1];
      end else begin
        sdout_d = act_r[DATA_WIDTH-1];
      end
    end else if (state_q == SHIFT) begin
      sdout_d = lrclk ? act_r[cnt_q] : act_l[cnt_q];
      if (cnt_q == '0) state_d = IDLE;
      else             cnt_d   = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      state_q     <= IDLE;
      prev_lr     <= lrclk;
      cnt_q       <= '0;
      sdout       <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      act_l       <= '0;
      act_r       <= '0;
      hold_l      <= '0;
      hold_r      <= '0;
      hold_full   <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_lr     <= lrclk;
      cnt_q       <= cnt_d;
      sdout       <= sdout_d;
      frame_start <= fs_d;
      underrun    <= ur_d;
      act_l       <= act_l_d;
      act_r       <= act_r_d;
      // A same-cycle accept only fills the buffer; the starting slot saw it empty.
      if (accept) begin
        hold_l    <= up.din_left;
        hold_r    <= up.din_right;
        hold_full <= 1'b1;
      end else if (hold_clr) begin
        hold_full <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_i2s_transmitter.sv
// Directed bench: bench-driven LRCLK slots, bit-by-bit check of sdout and status pulses.
module tb_i2s_transmitter;
  logic sclk = 1'b0;
  logic rst, lrclk;
  logic sdout, frame_start, underrun;
  int   tests = 0;
  int   fails = 0;
  logic mfull = 1'b0;

  i2s_tx_if #(.DATA_WIDTH(24)) up ();

  i2s_transmitter #(.DATA_WIDTH(24)) dut (
    .sclk        (sclk),
    .rst         (rst),
    .lrclk       (lrclk),
    .up          (up),
    .sdout       (sdout),
    .frame_start (frame_start),
    .underrun    (underrun)
  );

  always #5 sclk = ~sclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One LRCLK slot of len cycles; word is the expected serial word for that slot.
  task automatic run_slot(input logic lr, input int len, input logic [23:0] word,
                          input logic exp_ur, input logic offer,
                          input logic [23:0] ol, input logic [23:0] orr, input string tag);
    logic acc;
    logic eb;
    acc   = offer && !mfull;
    lrclk = lr;
    if (offer) begin
      up.din_left  = ol;
      up.din_right = orr;
      up.din_valid = 1'b1;
    end
    if (acc)      mfull = 1'b1;
    else if (!lr) mfull = 1'b0;
    for (int i = 0; i < len; i++) begin
      @(posedge sclk); #1;
      up.din_valid = 1'b0;
      eb = (i < 24) ? word[23-i] : 1'b0;
      chk($sformatf("%s_bit%0d", tag, i), {31'b0, sdout}, {31'b0, eb});
      if (i == 0) begin
        chk({tag, "_fs"}, {31'b0, frame_start}, {31'b0, ~lr});
        chk({tag, "_ur"}, {31'b0, underrun}, {31'b0, exp_ur});
      end else begin
        chk($sformatf("%s_fs%0d", tag, i), {31'b0, frame_start}, 32'd0);
        chk($sformatf("%s_ur%0d", tag, i), {31'b0, underrun}, 32'd0);
      end
      chk($sformatf("%s_rdy%0d", tag, i), {31'b0, up.din_ready}, {31'b0, ~mfull});
    end
  endtask

  initial begin
    rst = 1'b1; lrclk = 1'b1;
    up.din_valid = 1'b0; up.din_left = '0; up.din_right = '0;
    repeat (2) begin @(posedge sclk); #1; end
    chk("rst_sdout", {31'b0, sdout}, 32'd0);
    chk("rst_fs",    {31'b0, frame_start}, 32'd0);
    chk("rst_ur",    {31'b0, underrun}, 32'd0);
    chk("rst_rdy",   {31'b0, up.din_ready}, 32'd0);
    rst = 1'b0;
    @(posedge sclk); #1;
    chk("post_rst_rdy",   {31'b0, up.din_ready}, 32'd1);
    chk("post_rst_sdout", {31'b0, sdout}, 32'd0);
    chk("post_rst_ur",    {31'b0, underrun}, 32'd0);

    // Idle frames: zeros, underrun on every left slot.
    run_slot(0, 32, 24'h0, 1, 0, 24'h0, 24'h0, "idle_l0");
    run_slot(1, 32, 24'h0, 0, 0, 24'h0, 24'h0, "idle_r0");
    run_slot(0, 32, 24'h0, 1, 0, 24'h0, 24'h0, "idle_l1");
    run_slot(1, 32, 24'h0, 0, 1, 24'hA55AC3, 24'h000001, "idle_r1");

    // Loaded pair, then consecutive loopback-style frames.
    run_slot(0, 32, 24'hA55AC3, 0, 0, 24'h0, 24'h0, "ld_l");
    run_slot(1, 32, 24'h000001, 0, 1, 24'h123456, 24'hFEDCBA, "ld_r");
    run_slot(0, 32, 24'h123456, 0, 0, 24'h0, 24'h0, "fa_l");
    run_slot(1, 32, 24'hFEDCBA, 0, 1, 24'hFEDCBA, 24'h123456, "fa_r");
    run_slot(0, 32, 24'hFEDCBA, 0, 0, 24'h0, 24'h0, "fb_l");
    run_slot(1, 32, 24'h123456, 0, 0, 24'h0, 24'h0, "fb_r");

    // Offer on the falling-edge cycle with empty buffer: underrun, plays next frame.
    run_slot(0, 32, 24'h0, 1, 1, 24'h5A5A5A, 24'hC3C3C3, "same_l");
    run_slot(1, 32, 24'h0, 0, 0, 24'h0, 24'h0, "same_r");
    run_slot(0, 32, 24'h5A5A5A, 0, 0, 24'h0, 24'h0, "next_l");
    run_slot(1, 32, 24'hC3C3C3, 0, 1, 24'hFFFFFF, 24'hAAAAAA, "next_r");

    // 16-cycle slots truncate the word; next MSB follows immediately.
    run_slot(0, 16, 24'hFFFFFF, 0, 0, 24'h0, 24'h0, "short_l");
    run_slot(1, 16, 24'hAAAAAA, 0, 0, 24'h0, 24'h0, "short_r");
    run_slot(0, 16, 24'h0, 1, 0, 24'h0, 24'h0, "short_l2");
    run_slot(1, 16, 24'h0, 0, 1, 24'h123456, 24'h654321, "short_r2");

    // Reset mid left word.
    lrclk = 1'b0;
    mfull = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge sclk); #1;
      chk($sformatf("mid_bit%0d", i), {31'b0, sdout}, {31'b0, ((24'h123456 >> (23 - i)) & 24'h1) != 0});
    end
    rst = 1'b1;
    @(posedge sclk); #1;
    chk("mid_rst_sdout", {31'b0, sdout}, 32'd0);
    chk("mid_rst_rdy",   {31'b0, up.din_ready}, 32'd0);
    chk("mid_rst_fs",    {31'b0, frame_start}, 32'd0);
    rst = 1'b0;
    #1;
    chk("mid_post_rdy",  {31'b0, up.din_ready}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      @(posedge sclk); #1;
      chk($sformatf("mid_pad%0d", i), {31'b0, sdout}, 32'd0);
      chk($sformatf("mid_ur%0d", i),  {31'b0, underrun}, 32'd0);
    end
    run_slot(1, 32, 24'h0, 0, 0, 24'h0, 24'h0, "after_r");
    run_slot(0, 32, 24'h0, 1, 0, 24'h0, 24'h0, "after_l");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
